// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg -- shared CPU definitions used by the program-counter control
// block and the control unit.
//   pc_op_e : program-counter operation codes (3 bits).
package pc_ctrl_pkg;

  localparam int OP_W  = 3;
  localparam int OFS_W = 8;

  typedef enum logic [OP_W-1:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_LOAD = 3'd2,
    OP_REL  = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5,
    OP_CLR  = 3'd6,
    OP_RSVD = 3'd7
  } pc_op_e;

endpackage

// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if -- request/status bundle of the program-counter controller.
//   en, op, target, offset         : driven by the master (control unit)
//   pc, sp, stack_full/empty, err  : driven by the slave (pc_ctrl)
// Parameters: AW address width, SPW stack-pointer width.
interface pc_ctrl_if #(
  parameter int AW  = 8,
  parameter int SPW = 3
);
  import pc_ctrl_pkg::*;

  logic              en;
  logic [OP_W-1:0]   op;
  logic [AW-1:0]     target;
  logic [OFS_W-1:0]  offset;
  logic [AW-1:0]     pc;
  logic [SPW-1:0]    sp;
  logic              stack_full;
  logic              stack_empty;
  logic              err;

  modport master (
    output en, op, target, offset,
    input  pc, sp, stack_full, stack_empty, err
  );

  modport slave (
    input  en, op, target, offset,
    output pc, sp, stack_full, stack_empty, err
  );

endinterface

// File: rtl/pc_ctrl_ret_stack.sv
// pc_ret_stack -- LIFO of return addresses for pc_ctrl.
//   clk, rst      : clock, async active-high reset (occupancy only)
//   clr           : synchronous empty
//   push/pop, din : push din / drop top entry (ignored when full/empty)
//   top           : current top entry (don't-care when empty)
//   sp, full, empty : occupancy and its decodes
module pc_ret_stack #(
  parameter int AW    = 8,
  parameter int DEPTH = 4,
  parameter int SPW   = $clog2(DEPTH+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           push,
  input  logic           pop,
  input  logic [AW-1:0]  din,
  output logic [AW-1:0]  top,
  output logic [SPW-1:0] sp,
  output logic           full,
  output logic           empty
);
  localparam int IW = $clog2(DEPTH);

  logic [AW-1:0]  mem_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic [IW-1:0]  wr_idx, rd_idx;

  assign full   = (sp_q == SPW'(DEPTH));
  assign empty  = (sp_q == '0);
  assign wr_idx = sp_q[IW-1:0];
  assign rd_idx = IW'(sp_q - 1'b1);
  assign top    = mem_q[rd_idx];
  assign sp     = sp_q;

  always_comb begin
    sp_d = sp_q;
    if (clr)                sp_d = '0;
    else if (push && !full) sp_d = sp_q + 1'b1;
    else if (pop && !empty) sp_d = sp_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sp_q <= '0;
    else     sp_q <= sp_d;
  end

  // Entries are written before they are ever read, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl -- program counter with increment, absolute/relative jumps and an
// optional return stack for CALL/RET.
//   clk, rst : clock, async active-high reset (pc=RST_VEC, sp=0, err=0)
//   bus      : pc_ctrl_if.slave (en, op, target, offset in;
//              pc, sp, stack_full, stack_empty, err out)
// Build option: define PC_CTRL_CALL_STACK_EN to include the return stack;
// without it CALL/RET behave as HOLD and the stack status is constant empty.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int            AW      = 8,
  parameter int            DEPTH   = 4,
  parameter logic [AW-1:0] RST_VEC = '0
) (
  input logic      clk,
  input logic      rst,
  pc_ctrl_if.slave bus
);

  logic [AW-1:0] pc_q, pc_d;
  logic          err_q, err_d;
  logic          push, pop, clr;

  // Sign-extend the 8-bit displacement, then keep the low AW bits; this
  // also truncates it when AW is narrower than 8.
  function automatic logic [AW-1:0] sext_off(input logic signed [OFS_W-1:0] off);
    logic signed [15:0] wide;
    wide = 16'(off);
    return wide[AW-1:0];
  endfunction

`ifdef PC_CTRL_CALL_STACK_EN
  logic [AW-1:0] stk_top;
  logic          stk_full, stk_empty;

  pc_ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH),
    .SPW   ($bits(bus.sp))
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (pc_q + 1'b1),
    .top   (stk_top),
    .sp    (bus.sp),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign bus.stack_full  = stk_full;
  assign bus.stack_empty = stk_empty;
`else
  assign bus.sp          = '0;
  assign bus.stack_full  = 1'b0;
  assign bus.stack_empty = 1'b1;
`endif

  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
    clr   = 1'b0;
    if (bus.en) begin
      case (bus.op)
        OP_INC:  pc_d = pc_q + 1'b1;
        OP_LOAD: pc_d = bus.target;
        OP_REL:  pc_d = pc_q + sext_off(bus.offset);
`ifdef PC_CTRL_CALL_STACK_EN
        OP_CALL: begin
          if (stk_full) err_d = 1'b1;
          else begin
            push = 1'b1;
            pc_d = bus.target;
          end
        end
        OP_RET: begin
          if (stk_empty) err_d = 1'b1;
          else begin
            pop  = 1'b1;
            pc_d = stk_top;
          end
        end
`endif
        OP_CLR: begin
          pc_d  = RST_VEC;
          err_d = 1'b0;
          clr   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RST_VEC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign bus.pc  = pc_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;
  import pc_ctrl_pkg::*;

  localparam int            AW      = 8;
  localparam int            DEPTH   = 4;
  localparam int            SPW     = $clog2(DEPTH+1);
  localparam logic [AW-1:0] RST_VEC = 8'h00;
  localparam int            MASK    = (1 << AW) - 1;
`ifdef PC_CTRL_CALL_STACK_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_ctrl_if #(.AW(AW), .SPW(SPW)) bus ();

  pc_ctrl #(.AW(AW), .DEPTH(DEPTH), .RST_VEC(RST_VEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pc as an integer, return stack as a queue.
  int unsigned m_pc  = RST_VEC;
  int unsigned m_stk[$];
  bit          m_err = 1'b0;

  function automatic void model_reset();
    m_pc  = RST_VEC;
    m_stk.delete();
    m_err = 1'b0;
  endfunction

  function automatic void model_step(bit en, int op, int unsigned tgt, logic [7:0] off);
    int o;
    if (!en) return;
    o = int'($signed(off));
    case (op)
      1: m_pc = (m_pc + 1) & MASK;
      2: m_pc = tgt & MASK;
      3: m_pc = (int'(m_pc) + o) & MASK;
      4: if (STK_EN) begin
           if (m_stk.size() == DEPTH) m_err = 1'b1;
           else begin
             m_stk.push_back((m_pc + 1) & MASK);
             m_pc = tgt & MASK;
           end
         end
      5: if (STK_EN) begin
           if (m_stk.size() == 0) m_err = 1'b1;
           else m_pc = m_stk.pop_back();
         end
      6: begin m_pc = RST_VEC; m_stk.delete(); m_err = 1'b0; end
      default: ;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(string tag);
    chk({tag, ".pc"},    32'(bus.pc),          m_pc);
    chk({tag, ".sp"},    32'(bus.sp),          m_stk.size());
    chk({tag, ".full"},  32'(bus.stack_full),  32'(m_stk.size() == DEPTH));
    chk({tag, ".empty"}, 32'(bus.stack_empty), 32'(m_stk.size() == 0));
    chk({tag, ".err"},   32'(bus.err),         32'(m_err));
  endtask

  // Apply one operation across one rising edge, then compare after the edge.
  task automatic step(string tag, bit en, int op, int unsigned tgt = 0, logic [7:0] off = 8'h00);
    bus.en     = en;
    bus.op     = 3'(op);
    bus.target = AW'(tgt);
    bus.offset = off;
    @(posedge clk);
    model_step(en, op, tgt, off);
    #1;
    chk_state(tag);
  endtask

  initial begin
    bus.en = 1'b0; bus.op = 3'd0; bus.target = '0; bus.offset = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset");
    chk("reset.pc_const", 32'(bus.pc), 32'(RST_VEC));
    rst = 1'b0;

    // Increment from reset and wrap.
    step("inc1", 1, OP_INC);
    step("inc2", 1, OP_INC);
    step("inc3", 1, OP_INC);
    chk("inc3.const", 32'(bus.pc), 32'h3);
    step("loadff", 1, OP_LOAD, 8'hFF);
    step("wrap", 1, OP_INC);
    chk("wrap.const", 32'(bus.pc), 32'h0);

    // Relative jumps and enable freeze.
    step("load10", 1, OP_LOAD, 8'h10);
    step("rel_m2", 1, OP_REL, 0, 8'hFE);
    chk("rel_m2.const", 32'(bus.pc), 32'h0E);
    step("rel_p5", 1, OP_REL, 0, 8'h05);
    chk("rel_p5.const", 32'(bus.pc), 32'h13);
    step("load_en0", 0, OP_LOAD, 8'h40);
    chk("load_en0.const", 32'(bus.pc), 32'h13);
    step("hold", 1, OP_HOLD, 8'h55);
    step("rsvd", 1, OP_RSVD, 8'h55, 8'h7F);

    // CALL/RET pair.
    step("load20", 1, OP_LOAD, 8'h20);
    step("call80", 1, OP_CALL, 8'h80);
`ifdef PC_CTRL_CALL_STACK_EN
    chk("call80.const", 32'(bus.pc), 32'h80);
`else
    chk("call_off.const", 32'(bus.pc), 32'h20);
`endif
    step("ret", 1, OP_RET);
`ifdef PC_CTRL_CALL_STACK_EN
    chk("ret.const", 32'(bus.pc), 32'h21);
`endif

    // Overflow, underflow, sticky err, CLR.
    for (int i = 0; i < DEPTH; i++) step($sformatf("callfill%0d", i), 1, OP_CALL, 8'h30 + i);
    step("call_ovf", 1, OP_CALL, 8'hA0);
    step("call_en0", 0, OP_CALL, 8'hB0);
    for (int i = 0; i < DEPTH; i++) step($sformatf("retdrain%0d", i), 1, OP_RET);
    step("ret_unf", 1, OP_RET);
    step("inc_err", 1, OP_INC);
    step("clr", 1, OP_CLR, 8'hEE);
    chk("clr.const", 32'(bus.pc), 32'(RST_VEC));

    // Asynchronous reset between edges in the middle of a CALL sequence.
    step("load50", 1, OP_LOAD, 8'h50);
    step("acall1", 1, OP_CALL, 8'h60);
    step("acall2", 1, OP_CALL, 8'h70);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    chk_state("async_rst");
    chk("async_rst.pc_const", 32'(bus.pc), 32'(RST_VEC));
    chk("async_rst.sp_const", 32'(bus.sp), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_rst_inc", 1, OP_INC);

    // Randomised operations against the model.
    for (int i = 0; i < 600; i++) begin
      int op;
      bit en;
      op = int'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 4) op = OP_CLR + (op & 0);
      else if (op == OP_CLR && $urandom_range(0, 3) != 0) op = OP_CALL;
      en = ($urandom_range(0, 9) != 0);
      step($sformatf("rnd%0d", i), en, op, $urandom, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
